// File: rtl/avalon_pix_writer.sv
// Avalon-MM 32bpp-to-16bpp pixel write adapter: packs 128-bit X8R8G8B8 slave beats into 64-bit
// RGB565/X1R5G5B5 DDR bursts. Define AVALON_PIX_WRITER_DITHER_EN to add 2x2 ordered dithering.
module avalon_pix_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int BW         = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          control_address,
  input  logic          control_write,
  input  logic [31:0]   control_writedata,
  input  logic [31:0]   slave_address,
  input  logic [BW-1:0] slave_burstcount,
  input  logic          slave_write,
  input  logic [127:0]  slave_writedata,
  input  logic [15:0]   slave_byteenable,
  output logic          slave_waitrequest,
  output logic [31:0]   master_address,
  output logic [BW-1:0] master_burstcount,
  output logic          master_write,
  output logic [63:0]   master_writedata,
  output logic [7:0]    master_byteenable,
  input  logic          master_waitrequest
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [31:0]   r_base;
  logic          r_fmt;
  logic          r_burstFmt;
  logic [BW-1:0] r_remaining;
  logic [31:0]   r_mAddr;
  logic [BW-1:0] r_mCount;
  logic          r_ready;

  logic [71:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic [71:0]   w_head;

  logic          w_slaveWait;
  logic          w_accept;
  logic          w_pop;
  logic [BW-1:0] w_firstCount;
  logic          w_fmtSel;
  logic [63:0]   w_packData;
  logic [7:0]    w_packBe;
  logic          w_unused;

`ifdef AVALON_PIX_WRITER_DITHER_EN
  logic          r_beatOdd;
  logic          w_beatOdd;

  function automatic logic [1:0] ditherOffset(input logic beatOdd, input logic pixOdd);
    case ({beatOdd, pixOdd})
      2'b00:   return 2'd0;
      2'b01:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] satAdd(input logic [7:0] c, input logic [2:0] d);
    logic [8:0] sum;
    sum = {1'b0, c} + {6'd0, d};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [15:0] packPixel(input logic [23:0] pix, input logic fmt565,
                                            input logic [1:0] dith);
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
    red = satAdd(pix[23:16], {dith, 1'b0});
    grn = satAdd(pix[15:8], {1'b0, dith});
    blu = satAdd(pix[7:0], {dith, 1'b0});
    return fmt565 ? {red[7:3], grn[7:2], blu[7:3]} : {1'b0, red[7:3], grn[7:3], blu[7:3]};
  endfunction
`else
  function automatic logic [15:0] packPixel(input logic [23:0] pix, input logic fmt565);
    return fmt565 ? {pix[23:19], pix[15:10], pix[7:3]}
                  : {1'b0, pix[23:19], pix[15:11], pix[7:3]};
  endfunction
`endif

  assign w_count      = r_wrPtr - r_rdPtr;
  assign w_full       = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty      = (r_wrPtr == r_rdPtr);
  assign w_head       = r_mem[r_rdPtr[AW-1:0]];

  // No bypass: a full FIFO stalls the slave even if the master pops this cycle.
  assign w_slaveWait  = !r_ready || w_full || !(r_state inside {IDLE, FILL});
  assign w_accept     = slave_write && !w_slaveWait;
  assign w_pop        = !w_empty && !master_waitrequest;
  assign w_firstCount = (slave_burstcount == '0) ? BW'(1) : slave_burstcount;
  assign w_fmtSel     = (r_state == IDLE) ? r_fmt : r_burstFmt;

`ifdef AVALON_PIX_WRITER_DITHER_EN
  assign w_beatOdd    = (r_state == IDLE) ? 1'b0 : r_beatOdd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beatOdd <= 1'b0;
    end else if (w_accept) begin
      r_beatOdd <= !w_beatOdd;
    end
  end
`endif

  always_comb begin
    w_packData = '0;
    w_packBe   = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef AVALON_PIX_WRITER_DITHER_EN
      w_packData[16*i +: 16] = packPixel(slave_writedata[32*i +: 24], w_fmtSel,
                                         ditherOffset(w_beatOdd, i[0]));
`else
      w_packData[16*i +: 16] = packPixel(slave_writedata[32*i +: 24], w_fmtSel);
`endif
      w_packBe[2*i +: 2]     = {2{|slave_byteenable[4*i +: 3]}};
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (w_firstCount == BW'(1)) ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (w_accept && r_remaining == BW'(1)) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty || (w_pop && w_count == (AW+1)'(1))) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_fmt       <= 1'b0;
      r_burstFmt  <= 1'b0;
      r_remaining <= '0;
      r_mAddr     <= '0;
      r_mCount    <= '0;
      r_ready     <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
    end else begin
      r_state <= w_nextState;
      r_ready <= 1'b1;
      if (control_write) begin
        if (control_address) begin
          r_fmt <= control_writedata[0];
        end else begin
          r_base <= control_writedata;
        end
      end
      // Burst parameters are captured only from the first beat of each burst.
      if (w_accept) begin
        if (r_state == IDLE) begin
          r_mAddr     <= r_base + {1'b0, slave_address[31:1]};
          r_mCount    <= w_firstCount;
          r_burstFmt  <= r_fmt;
          r_remaining <= w_firstCount - BW'(1);
        end else begin
          r_remaining <= r_remaining - BW'(1);
        end
        r_wrPtr <= r_wrPtr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wrPtr[AW-1:0]] <= {w_packBe, w_packData};
    end
  end

  assign slave_waitrequest = w_slaveWait;
  assign master_address    = r_mAddr;
  assign master_burstcount = r_mCount;
  assign master_write      = !w_empty;
  assign master_writedata  = w_empty ? 64'd0 : w_head[63:0];
  assign master_byteenable = w_empty ? 8'd0 : w_head[71:64];

  assign w_unused = ^{slave_address[0], slave_byteenable[15], slave_byteenable[11],
                      slave_byteenable[7], slave_byteenable[3], slave_writedata[127:120],
                      slave_writedata[95:88], slave_writedata[63:56], slave_writedata[31:24]};

endmodule
